// File: rtl/solve_ctrl.sv
// solve_ctrl: host-side driver and reader for the cube solver top.
// Collects the 120-bit cube state from host word writes. Resets, arms and runs
// the solver, logs each move it reports, and flags done, fail or timeout.
module solve_ctrl #(
  parameter int MAX_MOVES   = 10,
  parameter int TIMEOUT     = 1000000,
  parameter int SRST_CYCLES = 4,
  parameter int LOG_DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         start,
  input  logic [3:0]   rd_idx,
  output logic [7:0]   rd_data,
  output logic [119:0] cube_d,
  output logic         run,
  output logic         solver_rst_n,
  input  logic [3:0]   solver_addr,
  input  logic [3:0]   solver_step,
  input  logic         solver_q,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic         timeout,
  output logic [4:0]   move_cnt
);
  localparam int SW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SRST, ARM, RUN, DONE, FAIL} state_e;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] step;
  } move_t;

  state_e                    state_q, state_d;
  logic [SW-1:0]             srst_cnt_q, srst_cnt_d;
  logic [23:0]               cyc_q, cyc_d;
  logic                      timeout_q, timeout_d;
  logic [4:0]                move_cnt_q, move_cnt_d;
  move_t [LOG_DEPTH-1:0]     log_q, log_d;
  logic [2:0][31:0]          w_q, w_d;
  logic [23:0]               w3_q, w3_d;
  logic [3:0]                addr_q;
  logic                      start_q;
  logic [7:0]                rd_data_q, rd_data_d;
  logic                      run_q, run_d;
  logic                      srn_q, srn_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      fail_q, fail_d;

  logic start_pulse;
  logic host_wr_ok;
  logic addr_hi;
  logic new_move;

  // A start held high only counts once, on its rising edge.
  assign start_pulse = start & ~start_q;
  assign host_wr_ok  = (state_q == IDLE) || (state_q == DONE) || (state_q == FAIL);
  assign addr_hi     = (solver_addr >= 4'(MAX_MOVES));
  assign new_move    = (solver_addr != addr_q) && (solver_addr != 4'd0);

  // Next-state, counters, move log, state words and registered outputs.
  always_comb begin
    state_d    = state_q;
    srst_cnt_d = srst_cnt_q;
    cyc_d      = cyc_q;
    timeout_d  = timeout_q;
    move_cnt_d = move_cnt_q;
    log_d      = log_q;
    w_d        = w_q;
    w3_d       = w3_q;

    unique case (state_q)
      IDLE, DONE, FAIL: if (start_pulse) state_d = SRST;
      SRST: begin
        if (srst_cnt_q == SW'(SRST_CYCLES - 1)) state_d = ARM;
        else                                     srst_cnt_d = srst_cnt_q + 1'b1;
      end
      ARM: state_d = RUN;
      RUN: begin
        cyc_d = cyc_q + 24'd1;
        // A solved flag beats both the move limit and the cycle budget.
        if (solver_q)                         state_d = DONE;
        else if (addr_hi)                     state_d = FAIL;
        else if (cyc_q == 24'(TIMEOUT - 1)) begin
          state_d   = FAIL;
          timeout_d = 1'b1;
        end
        if (new_move) begin
          log_d[solver_addr - 4'd1] = '{addr: solver_addr, step: solver_step};
          if (move_cnt_q != 5'(LOG_DEPTH)) move_cnt_d = move_cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every (re)start begins from a clean log and fresh counters.
    if (state_d == SRST && state_q != SRST) begin
      srst_cnt_d = '0;
      cyc_d      = '0;
      timeout_d  = 1'b0;
      move_cnt_d = '0;
      log_d      = '0;
    end

    // Cube words are frozen while the solver owns them.
    if (wr_en && host_wr_ok) begin
      unique case (wr_addr)
        2'd0: w_d[0] = wr_data;
        2'd1: w_d[1] = wr_data;
        2'd2: w_d[2] = wr_data;
        2'd3: w3_d   = wr_data[23:0];
        default: ;
      endcase
    end

    rd_data_d = log_q[rd_idx];

    run_d  = (state_d == ARM);
    srn_d  = (state_d == ARM) || (state_d == RUN) || (state_d == DONE) || (state_d == FAIL);
    busy_d = (state_d == SRST) || (state_d == ARM) || (state_d == RUN);
    done_d = (state_d == DONE);
    fail_d = (state_d == FAIL);
  end

  // Single register bank for FSM, datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      srst_cnt_q <= '0;
      cyc_q      <= '0;
      timeout_q  <= 1'b0;
      move_cnt_q <= '0;
      log_q      <= '0;
      w_q        <= '0;
      w3_q       <= '0;
      addr_q     <= '0;
      start_q    <= 1'b0;
      rd_data_q  <= '0;
      run_q      <= 1'b0;
      srn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      srst_cnt_q <= srst_cnt_d;
      cyc_q      <= cyc_d;
      timeout_q  <= timeout_d;
      move_cnt_q <= move_cnt_d;
      log_q      <= log_d;
      w_q        <= w_d;
      w3_q       <= w3_d;
      addr_q     <= solver_addr;
      start_q    <= start;
      rd_data_q  <= rd_data_d;
      run_q      <= run_d;
      srn_q      <= srn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign cube_d       = {w3_q, w_q[2], w_q[1], w_q[0]};
  assign rd_data      = rd_data_q;
  assign run          = run_q;
  assign solver_rst_n = srn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign move_cnt     = move_cnt_q;

endmodule
